regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register data width in bits.
REQ-002 Parameter NREGS, default 8, SHALL set the number of architectural registers (2..15).
REQ-003 Parameter ADDR_W, default 4, SHALL set the register specifier width.
REQ-004 Parameter NOREG, default 4'hF, SHALL set the specifier value meaning "no register".
REQ-005 Parameter INIT_VAL, default 0, SHALL set the value loaded into every register by the init sequence.
REQ-006 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-007 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-008 srcA, srcB  input  ADDR_W  SHALL be the read specifiers for ports A and B.
REQ-009 dstE, dstM  input  ADDR_W  SHALL be the write specifiers for the E (ALU) and M (memory) ports.
REQ-010 valE, valM  input  DATA_W  SHALL be the write data for ports E and M.
REQ-011 valA, valB  output  DATA_W  SHALL be the read data for ports A and B.
REQ-012 busy  output  1  SHALL be high while the init sequence runs.

Function
REQ-013 The block SHALL hold NREGS registers of DATA_W bits and have two states, INIT and RUN.
REQ-014 In INIT, the block SHALL write INIT_VAL to register cnt each cycle, with cnt counting 0..NREGS-1, then enter RUN on the cycle after cnt reaches NREGS-1.
REQ-015 INIT SHALL last exactly NREGS cycles after rst deasserts; busy=1 throughout INIT and 0 in RUN.
REQ-016 In INIT, the block SHALL ignore dstE/dstM writes, and valA and valB SHALL read 0.
REQ-017 In RUN, a write port SHALL update regs[dst] at the clock edge when dst != NOREG and dst < NREGS; other specifier values are discarded.
REQ-018 If dstE == dstM, both valid, the block SHALL store valM (M port has priority).
REQ-019 In RUN, reads SHALL be combinational: valX = 0 if srcX == NOREG or srcX >= NREGS.
REQ-020 Otherwise, valX SHALL return valM if srcX == dstM (valid), else valE if srcX == dstE (valid), else regs[srcX] (same-cycle write bypass, M before E).
REQ-021 Ports A and B SHALL be independent; srcA == srcB SHALL return identical data.
REQ-022 The read outputs SHALL be fully defined every cycle, with no latches and no held values.

Reset
REQ-023 rst=1 at a clock edge SHALL force state=INIT, cnt=0, busy=1, regardless of the current state.
REQ-024 A reset mid-INIT or mid-RUN SHALL restart the full NREGS-cycle init sequence.
REQ-025 Register contents SHALL be defined only through the init sequence; no initial blocks are used.
REQ-026 While rst=1, busy SHALL read 1 and valA/valB SHALL read 0.

Structure
REQ-027 The NOREG encoding, the default widths, and the state encoding (INIT=0, RUN=1) SHALL live in the shared defines/package used by the pipeline stages.
REQ-028 The init counter plus the FSM SHALL be one sub-module, rf_init_seq (outputs: busy, init_we, init_idx).
REQ-029 The bypass and read-mux logic SHALL be written once and instantiated per read port.

Verification
REQ-030 Reset then idle (defaults): busy is high for exactly 8 cycles after rst falls, and every read returns 0 afterwards.
REQ-031 In RUN: dstE=2, valE=32'h12345678; next cycle srcA=2 -> valA=32'h12345678. In the same cycle as the write, srcB=2 -> valB=32'h12345678 via bypass.
REQ-032 dstE=dstM=4, valE=32'hAAAA0000, valM=32'h0000BBBB: same-cycle srcA=4 and the next-cycle read both return 32'h0000BBBB.
REQ-033 srcA=NOREG and srcB=9 (NREGS=8) -> valA=0, valB=0. A write with dstE=9 leaves all registers unchanged.
REQ-034 Write 32'hDEADBEEF to reg 1, assert rst for one cycle at cycle 3 of RUN: busy is high for 8 cycles, then reg 1 reads 0. A write issued during INIT is dropped.
REQ-035 Parameter sweep with NREGS=15, DATA_W=64, INIT_VAL=64'h1: INIT lasts 15 cycles, all 15 registers read 64'h1, and reg 14 is writable and readable.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared register-file encodings, default widths and FSM state type
package regfile_mp_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREGS = 8;
  localparam int DEF_ADDR_W = 4;
  localparam logic [DEF_ADDR_W-1:0] DEF_NOREG = 4'hF;
  typedef enum logic {INIT = 1'b0, RUN = 1'b1} rf_state_e;
endpackage

// File: rtl/regfile_mp_init_seq.sv
// rf_init_seq: post-reset init sequencer stepping init_idx 0..NREGS-1, then RUN
//   clk, rst in; busy high in INIT or reset; init_we/init_idx drive the init write
module rf_init_seq
  import regfile_mp_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_idx
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);
  rf_state_e state;
  logic [ADDR_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt <= '0;
    end else if (state == INIT) begin
      state <= cnt == LAST ? RUN : INIT;
      cnt <= cnt == LAST ? cnt : cnt + ADDR_W'(1);
    end
  end
  // rst is folded in so busy is high from the first reset cycle, before state is known
  assign busy = rst || state != RUN;
  assign init_we = !rst && state == INIT;
  assign init_idx = cnt;
endmodule

// File: rtl/regfile_mp_rd_port.sv
// rf_rd_port: one combinational read port with same-cycle write bypass (M over E)
//   en gates the port to RUN; src selects; dst_*/we_*/val_* are the live write ports
module rf_rd_port
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS = DEF_NREGS,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] NOREG = DEF_NOREG
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst_e,
  input  logic [ADDR_W-1:0] dst_m,
  input  logic              we_e,
  input  logic              we_m,
  input  logic [DATA_W-1:0] val_e,
  input  logic [DATA_W-1:0] val_m,
  input  logic [DATA_W-1:0] regs [NREGS],
  output logic [DATA_W-1:0] val
);
  logic [DATA_W-1:0] rd;
  // out-of-range specifiers match no entry and leave rd at zero
  always_comb begin
    rd = '0;
    for (int i = 0; i < NREGS; i++) rd = src == ADDR_W'(i) ? regs[i] : rd;
    val = !en || src == NOREG ? '0 :
          we_m && src == dst_m ? val_m :
          we_e && src == dst_e ? val_e : rd;
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: two-read/two-write register file with init sequence and write bypass
//   srcA/srcB read specifiers -> valA/valB; dstE/valE and dstM/valM write ports (M wins);
//   busy high while the register contents are being initialised
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS = DEF_NREGS,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] NOREG = DEF_NOREG,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] srcA,
  input  logic [ADDR_W-1:0] srcB,
  input  logic [ADDR_W-1:0] dstE,
  input  logic [ADDR_W-1:0] dstM,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic              busy
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);
  logic [DATA_W-1:0] regs [NREGS];
  logic init_we, we_e, we_m, run;
  logic [ADDR_W-1:0] init_idx;

  rf_init_seq #(.NREGS(NREGS), .ADDR_W(ADDR_W)) u_seq (
    .clk(clk), .rst(rst), .busy(busy), .init_we(init_we), .init_idx(init_idx)
  );

  assign run = !busy;
  assign we_e = run && dstE != NOREG && dstE <= LAST;
  assign we_m = run && dstM != NOREG && dstM <= LAST;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (init_we && init_idx == ADDR_W'(i)) regs[i] <= INIT_VAL;
      else if (we_m && dstM == ADDR_W'(i)) regs[i] <= valM;
      else if (we_e && dstE == ADDR_W'(i)) regs[i] <= valE;
    end
  end

  rf_rd_port #(.DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W), .NOREG(NOREG)) u_rd_a (
    .en(run), .src(srcA), .dst_e(dstE), .dst_m(dstM), .we_e(we_e), .we_m(we_m),
    .val_e(valE), .val_m(valM), .regs(regs), .val(valA)
  );

  rf_rd_port #(.DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W), .NOREG(NOREG)) u_rd_b (
    .en(run), .src(srcB), .dst_e(dstE), .dst_m(dstM), .we_e(we_e), .we_m(we_m),
    .val_e(valE), .val_m(valM), .regs(regs), .val(valB)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of init, bypass, priority, range and reset on two configurations
module tb_regfile_mp;
  logic clk = 0;
  always #5 clk = ~clk;

  logic rst, busy;
  logic [3:0] srcA, srcB, dstE, dstM;
  logic [31:0] valE, valM, valA, valB;

  logic rst2, busy2;
  logic [3:0] srcA2, srcB2, dstE2, dstM2;
  logic [63:0] valE2, valM2, valA2, valB2;

  int errors = 0, checks = 0, n;
  logic [31:0] exp_r [8];

  regfile_mp dut (
    .clk(clk), .rst(rst), .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
    .valE(valE), .valM(valM), .valA(valA), .valB(valB), .busy(busy)
  );

  regfile_mp #(.DATA_W(64), .NREGS(15), .INIT_VAL(64'h1)) dut2 (
    .clk(clk), .rst(rst2), .srcA(srcA2), .srcB(srcB2), .dstE(dstE2), .dstM(dstM2),
    .valE(valE2), .valM(valM2), .valA(valA2), .valB(valB2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_all();
    for (int i = 0; i < 8; i++) begin
      srcA = 4'(i);
      srcB = 4'(7 - i);
      #1;
      chk($sformatf("rdA%0d", i), valA, exp_r[i]);
      chk($sformatf("rdB%0d", 7 - i), valB, exp_r[7 - i]);
    end
  endtask

  initial begin
    rst = 1; srcA = 0; srcB = 0; dstE = 4'hF; dstM = 4'hF; valE = 0; valM = 0;
    rst2 = 1; srcA2 = 0; srcB2 = 0; dstE2 = 4'hF; dstM2 = 4'hF; valE2 = 0; valM2 = 0;
    foreach (exp_r[i]) exp_r[i] = 0;
    tick(); tick();
    chk("busy_in_rst", busy, 1);
    chk("valA_in_rst", valA, 0);
    rst = 0;
    n = 0;
    while (busy && n < 50) begin tick(); n++; end
    chk("init_len", n, 8);
    read_all();

    dstE = 2; valE = 32'h12345678; srcB = 2; #1;
    chk("bypass_e", valB, 32'h12345678);
    tick();
    dstE = 4'hF; srcA = 2; #1;
    chk("wr_e_rd", valA, 32'h12345678);
    exp_r[2] = 32'h12345678;

    dstE = 4; dstM = 4; valE = 32'hAAAA0000; valM = 32'h0000BBBB; srcA = 4; srcB = 4; #1;
    chk("byp_m_prio", valA, 32'h0000BBBB);
    chk("same_src", valB, 32'h0000BBBB);
    tick();
    dstE = 4'hF; dstM = 4'hF; #1;
    chk("wr_m_prio", valA, 32'h0000BBBB);
    exp_r[4] = 32'h0000BBBB;

    dstE = 5; dstM = 6; valE = 32'h55555555; valM = 32'h66666666; srcA = 5; srcB = 6; #1;
    chk("byp_e_only", valA, 32'h55555555);
    chk("byp_m_only", valB, 32'h66666666);
    tick();
    dstE = 4'hF; dstM = 4'hF;
    exp_r[5] = 32'h55555555; exp_r[6] = 32'h66666666;

    srcA = 4'hF; srcB = 9; dstE = 9; valE = 32'hFFFFFFFF; #1;
    chk("noreg_rd", valA, 0);
    chk("oor_rd", valB, 0);
    tick();
    dstE = 4'hF;
    read_all();

    dstE = 1; valE = 32'hDEADBEEF; tick();
    dstE = 4'hF; srcA = 1; #1;
    chk("wr_dead", valA, 32'hDEADBEEF);
    tick();
    rst = 1; tick();
    chk("busy_rst2", busy, 1);
    chk("valA_rst2", valA, 0);
    rst = 0; dstE = 3; valE = 32'h77777777; srcB = 3;
    n = 0;
    repeat (3) begin tick(); n++; end
    chk("init_rdA0", valA, 0);
    chk("init_rdB0", valB, 0);
    dstE = 4'hF;
    while (busy && n < 50) begin tick(); n++; end
    chk("reinit_len", n, 8);
    foreach (exp_r[i]) exp_r[i] = 0;
    read_all();

    tick();
    rst2 = 0;
    n = 0;
    while (busy2 && n < 50) begin tick(); n++; end
    chk("init15_len", n, 15);
    for (int i = 0; i < 15; i++) begin
      srcA2 = 4'(i); #1;
      chk($sformatf("init15_r%0d", i), valA2, 64'h1);
    end
    srcB2 = 4'hF; #1;
    chk("noreg15", valB2, 0);
    dstE2 = 14; valE2 = 64'hCAFEF00D12345678; tick();
    dstE2 = 4'hF; srcA2 = 14; srcB2 = 13; #1;
    chk("wr15_r14", valA2, 64'hCAFEF00D12345678);
    chk("wr15_r13", valB2, 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
